// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready load/store port, with a fixed
// number of wait states between request acceptance and response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    // Transaction being committed on this edge (entry into StResp).
    logic               cm_fire;
    logic               cm_we;
    logic [31:0]        cm_addr;
    logic [31:0]        cm_wdata;
    logic [3:0]         cm_be;
    logic [31:0]        cm_offset;
    logic [31:0]        cm_word;
    logic               cm_err;
    logic [IDX_W-1:0]   cm_idx;
    logic               mem_we;

    // With no wait states the commit happens on the accept edge, so the decode must
    // look at the live request instead of the latched copy.
    always_comb begin
        cm_fire  = 1'b0;
        cm_we    = we_q;
        cm_addr  = addr_q;
        cm_wdata = wdata_q;
        cm_be    = be_q;
        if (WAIT_CYCLES == 0) begin
            cm_fire  = (state_q == StIdle) && req_valid;
            cm_we    = req_we;
            cm_addr  = req_addr;
            cm_wdata = req_wdata;
            cm_be    = req_be;
        end else begin
            cm_fire  = (state_q == StWait) && (cnt_q == '0);
        end
    end

    always_comb begin
        cm_offset = cm_addr - ADDR_BASE;
        cm_word   = cm_offset >> 2;
        cm_err    = (cm_addr[1:0] != 2'b00) || (cm_addr < ADDR_BASE) ||
                    (cm_word >= DEPTH_WORDS);
        cm_idx    = cm_word[IDX_W-1:0];
        mem_we    = cm_fire && cm_we && !cm_err && !rst;
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cm_be[i]) begin
                    mem[cm_idx][8*i +: 8] <= cm_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (WAIT_CYCLES == 0) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= cm_err;
                            resp_rdata_q <= (!cm_err && !cm_we) ? mem[cm_idx] : '0;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= cm_err;
                        resp_rdata_q <= (!cm_err && !cm_we) ? mem[cm_idx] : '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance,
// checked every cycle against a transaction-level memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam longint BASE = 0;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) dut_w2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut_w0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Transaction-level model: one outstanding request per instance, response
    // visible from edge accept+WAIT_CYCLES, memory updated when the response appears.
    bit          busy      [2];
    int          resp_edge [2];
    logic [31:0] exp_data  [2];
    bit          exp_err   [2];
    bit          exp_known [2];
    bit          pend      [2];
    int          pend_idx  [2];
    logic [31:0] pend_data [2];
    logic [3:0]  pend_be   [2];
    logic [31:0] mdl_mem   [2][DEPTH];
    bit          mdl_ok    [2][DEPTH];

    task automatic model_step(input int d);
        bit     rv;
        bit     e;
        longint a;
        int     idx;
        string  p;
        p = $sformatf("dut%0d_", d);
        if (rst[d]) begin
            busy[d] = 0;
            pend[d] = 0;
            chk({p, "rst_req_ready"}, {31'b0, req_ready[d]}, 32'd1);
            chk({p, "rst_resp_valid"}, {31'b0, resp_valid[d]}, 32'd0);
            chk({p, "rst_resp_err"}, {31'b0, resp_err[d]}, 32'd0);
            chk({p, "rst_resp_rdata"}, resp_rdata[d], 32'd0);
        end else begin
            rv = busy[d] && (edges >= resp_edge[d]);
            if (rv && pend[d]) begin
                for (int i = 0; i < 4; i++)
                    if (pend_be[d][i]) mdl_mem[d][pend_idx[d]][8*i +: 8] = pend_data[d][8*i +: 8];
                pend[d] = 0;
            end
            chk({p, "req_ready"}, {31'b0, req_ready[d]}, {31'b0, !busy[d]});
            chk({p, "resp_valid"}, {31'b0, resp_valid[d]}, {31'b0, rv});
            chk({p, "resp_err"}, {31'b0, resp_err[d]}, {31'b0, rv && exp_err[d]});
            if (!rv || exp_known[d])
                chk({p, "resp_rdata"}, resp_rdata[d], rv ? exp_data[d] : 32'd0);
            if (rv && resp_ready[d]) begin
                busy[d] = 0;
            end else if (!busy[d] && req_valid[d]) begin
                a = longint'(req_addr[d]);
                e = (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
                exp_err[d]   = e;
                exp_data[d]  = 32'd0;
                exp_known[d] = 1;
                if (!e) begin
                    idx = int'((a - BASE) / 4);
                    if (req_we[d]) begin
                        pend[d]      = 1;
                        pend_idx[d]  = idx;
                        pend_data[d] = req_wdata[d];
                        pend_be[d]   = req_be[d];
                        if (req_be[d] == 4'hF) mdl_ok[d][idx] = 1;
                    end else begin
                        exp_data[d]  = mdl_mem[d][idx];
                        exp_known[d] = mdl_ok[d][idx];
                    end
                end
                busy[d]      = 1;
                resp_edge[d] = edges + 1 + wait_of(d);
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Completed responses of the zero-wait instance, {err, rdata}.
    logic [32:0] w0_log[$];
    always @(negedge clk)
        if (!rst[1] && resp_valid[1] && resp_ready[1]) w0_log.push_back({resp_err[1], resp_rdata[1]});

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected handshake (edge %0d)", name, edges);
    endtask

    // One transaction on the 2-wait instance. Starts and ends just after a rising edge.
    task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        int acc;
        rd  = 'x;
        er  = 'x;
        lat = -1;
        req_we[0] = we; req_addr[0] = addr; req_wdata[0] = wd; req_be[0] = be;
        req_valid[0] = 1'b1;
        resp_ready[0] = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        if (!req_ready[0]) begin timeout("txn_accept"); req_valid[0] = 1'b0; return; end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        acc = edges;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
        if (!resp_valid[0]) begin timeout("txn_resp"); return; end
        lat = edges - acc + 1;
        rd  = resp_rdata[0];
        er  = resp_err[0];
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 resp_ready[0] = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          acc;
    int          hs;
    int          acc_w0 [6];
    logic [31:0] w0_addr [6];
    logic        w0_we   [6];
    logic [31:0] w0_wd   [6];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
        end
        resp_ready[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0; rst[1] = 1'b0;

        // 1: store then load, 3-edge latency each
        txn0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("t1_store_lat", lat, 32'd3);
        chk("t1_store_rdata", rd, 32'd0);
        chk("t1_store_err", {31'b0, er}, 32'd0);
        txn0(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t1_load_lat", lat, 32'd3);
        chk("t1_load_rdata", rd, 32'hDEADBEEF);
        chk("t1_load_err", {31'b0, er}, 32'd0);

        // 2: partial byte-enable merge
        txn0(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
        txn0(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        txn0(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t2_merge_rdata", rd, 32'h11BB33DD);
        chk("t2_model_word", mdl_mem[0][8], 32'h11BB33DD);

        // 3: misaligned, out of range, no aliasing, empty byte enable
        txn0(1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_misalign_err", {31'b0, er}, 32'd1);
        chk("t3_misalign_rdata", rd, 32'd0);
        txn0(1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_range_err", {31'b0, er}, 32'd1);
        chk("t3_range_rdata", rd, 32'd0);
        txn0(1'b1, 32'h410, 32'h55555555, 4'hF, 0, rd, er, lat);
        chk("t3_alias_store_err", {31'b0, er}, 32'd1);
        txn0(1'b1, 32'h12, 32'h66666666, 4'hF, 0, rd, er, lat);
        chk("t3_misalign_store_err", {31'b0, er}, 32'd1);
        txn0(1'b1, 32'h10, 32'h77777777, 4'h0, 0, rd, er, lat);
        chk("t3_be0_err", {31'b0, er}, 32'd0);
        txn0(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_ram_unchanged_10", rd, 32'hDEADBEEF);
        txn0(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t3_last_word_err", {31'b0, er}, 32'd0);

        // 4: backpressure with a second request waiting
        req_we[0] = 1'b0; req_addr[0] = 32'h20; req_valid[0] = 1'b1; resp_ready[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        if (!req_ready[0]) timeout("t4_accept");
        @(posedge clk); #1;
        acc = edges;
        req_addr[0] = 32'h10;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
        if (!resp_valid[0]) timeout("t4_resp");
        chk("t4_lat", edges - acc + 1, 32'd3);
        chk("t4_rdata", resp_rdata[0], 32'h11BB33DD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'b0, resp_valid[0]}, 32'd1);
            chk("t4_hold_rdata", resp_rdata[0], 32'h11BB33DD);
            chk("t4_hold_req_ready", {31'b0, req_ready[0]}, 32'd0);
        end
        @(posedge clk); #1 resp_ready[0] = 1'b1;
        @(posedge clk); #1 resp_ready[0] = 1'b0;
        hs = edges;
        @(negedge clk);
        chk("t4_ready_after", {31'b0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("t4_accept_edge", edges, hs + 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
        if (!resp_valid[0]) timeout("t4_resp2");
        chk("t4_second_rdata", resp_rdata[0], 32'hDEADBEEF);
        @(posedge clk); #1 resp_ready[0] = 1'b1;
        @(posedge clk); #1 resp_ready[0] = 1'b0;

        // 6: reset during the wait of a store drops it
        txn0(1'b1, 32'h30, 32'h5, 4'hF, 0, rd, er, lat);
        req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h99; req_be[0] = 4'hF;
        req_valid[0] = 1'b1; resp_ready[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        if (!req_ready[0]) timeout("t6_accept");
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t6_in_wait", {31'b0, req_ready[0]}, 32'd0);
        #2 rst[0] = 1'b1;
        #1;
        chk("t6_async_req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("t6_async_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b0; resp_ready[0] = 1'b0;
        txn0(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6_not_committed", rd, 32'h5);

        // 5: zero-wait instance, back-to-back with resp_ready tied high
        w0_addr = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h3FF, 32'h800};
        w0_we   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        w0_wd   = '{32'hCAFEF00D, 32'h01020304, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            req_we[1] = w0_we[i]; req_addr[1] = w0_addr[i]; req_wdata[1] = w0_wd[i];
            req_be[1] = 4'hF; req_valid[1] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
            if (!req_ready[1]) timeout("t5_accept");
            @(posedge clk); #1;
            acc_w0[i] = edges;
            if (i > 0) chk("t5_period", acc_w0[i] - acc_w0[i-1], 32'd2);
        end
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_resp_count", w0_log.size(), 32'd6);
        if (w0_log.size() == 6) begin
            chk("t5_load40", w0_log[2], {1'b0, 32'hCAFEF00D});
            chk("t5_load44", w0_log[3], {1'b0, 32'h01020304});
            chk("t5_misalign", w0_log[4], {1'b1, 32'h0});
            chk("t5_range", w0_log[5], {1'b1, 32'h0});
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Word-addressed data-memory responder that serves the CPU's load/store port through a valid/ready request and response handshake.
It models a memory with a configurable number of wait states, so the CPU's stall logic can be exercised without changing CPU RTL.
It sits between the CPU's memory-access stage and on-chip RAM.
It checks alignment and range, and applies byte-enabled writes.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of 2.
WAIT_CYCLES, 2, cycles spent in WAIT between accept and response; 0 is legal.
ADDR_BASE, 32'h0000_0000, byte address of word 0.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  CPU presents a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
req_be  input  4  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
req_ready  output  1  responder accepts a request this cycle.
resp_valid  output  1  response available.
resp_ready  input  1  CPU consumes the response.
resp_rdata  output  32  load data; 0 for stores and for errors.
resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; wait counter = 0.
  - RAM contents are not reset.
- States are IDLE, WAIT and RESP. All outputs come from registers or a decode of state.
- Request acceptance:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a rising edge with state == IDLE and req_valid == 1.
  - On accept, latch we, addr, wdata and be.
  - Requests presented while req_ready = 0 are ignored; the CPU must hold them.
- IDLE:
  - On accept with WAIT_CYCLES == 0, go to RESP.
  - On accept otherwise, go to WAIT and load counter = WAIT_CYCLES-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP on the next edge.
  - Time spent in WAIT is exactly WAIT_CYCLES cycles.
- Entry into RESP (a single edge does all of the following):
  - Decode error: err = (addr[1:0] != 0) or (word index = (addr-ADDR_BASE)>>2 >= DEPTH_WORDS) or (addr < ADDR_BASE).
  - Store with no error: write the enabled bytes to RAM[index]; disabled bytes are unchanged; resp_rdata = 0.
  - Load with no error: resp_rdata = RAM[index] (value before any write in this transaction).
  - Any error: no RAM write; resp_rdata = 0; resp_err = 1.
  - resp_valid = 1.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until a rising edge with resp_ready == 1.
  - On that edge, go to IDLE, clear resp_valid, resp_err and resp_rdata, and set req_ready = 1.
- Latency: accept edge to resp_valid high is WAIT_CYCLES+1 edges. Minimum back-to-back period is WAIT_CYCLES+2 cycles.
- req_be == 0 on a store is a legal no-op write; it completes with err = 0.
- Read-after-write: a load accepted after a store's response completes returns the stored data.
- Reset mid-operation: an in-flight transaction is dropped. A store whose response edge has not occurred is not committed.
- Address wrap: an index computed at or beyond DEPTH_WORDS errors; it never aliases.

Test Plan:
1. WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> resp_valid 3 edges after each accept; load resp_rdata = 0xDEADBEEF; resp_err = 0.
2. Store 0x20 = 0x11223344 (be F), then store 0x20 = 0xAABBCCDD with be 4'b0101, then load 0x20 -> rdata 0x11BB33DD.
3. Load addr 0x0000_0006, and load addr 4*DEPTH_WORDS (0x400) -> resp_err = 1, rdata = 0; a following load of a valid address shows the RAM unchanged.
4. Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid, with req_valid held high for a new request -> response stable and req_ready stays 0. After resp_ready pulses, the new request is accepted on the next IDLE edge.
5. WAIT_CYCLES=0 build: back-to-back loads with resp_ready tied to 1 -> one response every 2 cycles; latency 1 edge.
6. Assert rst while in WAIT of a store to 0x30 (prior value 0x5) -> outputs go to reset values immediately; a later load of 0x30 returns 0x5.
